// File: rtl/aes_round_key_engine.sv
// Sequential AES-128 round-key generator: one KeyGeneration round per clock, streaming each key.
// Optional KEY_CACHE_EN keeps every expanded key so repeat requests for the same cipher key skip expansion.
module aes_round_key_engine #(
  parameter int KEY_W     = 128,
  parameter int MAX_ROUND = 10,
  parameter int RC_W      = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [KEY_W-1:0] key_in,
  input  logic [RC_W-1:0]  round_sel,
  output logic             busy,
  output logic             rk_valid,
  output logic [RC_W-1:0]  rk_idx,
  output logic [KEY_W-1:0] rk_out,
  output logic             done,
  output logic             err,
  output logic [KEY_W-1:0] key_out
);

  typedef enum logic [1:0] {IDLE, EXPAND, FINISH} state_t;

  localparam logic [RC_W-1:0] MAX_R = RC_W'(MAX_ROUND);

  state_t           state_reg, state_next;
  logic [RC_W-1:0]  cnt_reg, target_reg;
  logic             err_flag_reg;
  logic [KEY_W-1:0] work_reg;

  logic [RC_W-1:0]  cnt_inc;
  logic             accept, sel_err, cache_hit;
  logic [31:0]      rot_word, sub_word, temp_word;
  logic [31:0]      w0_next, w1_next, w2_next, w3_next;
  logic [KEY_W-1:0] next_key, finish_key;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // S-box = affine(x^254) in GF(2^8); the exponent chain avoids a 256-entry table.
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, x252, inv;
    x2   = gf_mul(a, a);
    x3   = gf_mul(x2, a);
    x6   = gf_mul(x3, x3);
    x12  = gf_mul(x6, x6);
    x15  = gf_mul(x12, x3);
    x30  = gf_mul(x15, x15);
    x60  = gf_mul(x30, x30);
    x120 = gf_mul(x60, x60);
    x240 = gf_mul(x120, x120);
    x252 = gf_mul(x240, x12);
    inv  = gf_mul(x252, x2);
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] rcon(input logic [RC_W-1:0] rc);
    logic [7:0] r;
    case (rc)
      4'd0:    r = 8'h01;
      4'd1:    r = 8'h02;
      4'd2:    r = 8'h04;
      4'd3:    r = 8'h08;
      4'd4:    r = 8'h10;
      4'd5:    r = 8'h20;
      4'd6:    r = 8'h40;
      4'd7:    r = 8'h80;
      4'd8:    r = 8'h1b;
      4'd9:    r = 8'h36;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  assign cnt_inc  = cnt_reg + RC_W'(1);
  assign accept   = (state_reg == IDLE) && start;
  assign sel_err  = round_sel > MAX_R;
  assign rot_word = {work_reg[23:0], work_reg[31:24]};

  for (genvar gi = 0; gi < 4; gi++) begin : g_sub
    assign sub_word[8*gi +: 8] = sbox(rot_word[8*gi +: 8]);
  end

  assign temp_word = sub_word ^ {rcon(cnt_reg), 24'h000000};
  assign w0_next   = work_reg[127:96] ^ temp_word;
  assign w1_next   = work_reg[95:64] ^ w0_next;
  assign w2_next   = work_reg[63:32] ^ w1_next;
  assign w3_next   = work_reg[31:0] ^ w2_next;
  assign next_key  = {w0_next, w1_next, w2_next, w3_next};

`ifdef KEY_CACHE_EN
  logic [KEY_W-1:0] cache_mem [0:MAX_ROUND];
  logic [KEY_W-1:0] cache_tag_reg, cache_rd_reg;
  logic [RC_W-1:0]  cache_max_reg, rd_addr;
  logic             cache_valid_reg, hit_reg;

  assign cache_hit  = cache_valid_reg && (key_in == cache_tag_reg) && (round_sel <= cache_max_reg);
  assign rd_addr    = sel_err ? '0 : round_sel;
  assign finish_key = hit_reg ? cache_rd_reg : work_reg;

  // Storage has no reset; the valid bit alone invalidates it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (accept && !sel_err && !cache_hit) cache_mem[0] <= key_in;
      else if (state_reg == EXPAND)         cache_mem[cnt_inc] <= next_key;
      if (accept) cache_rd_reg <= cache_mem[rd_addr];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cache_valid_reg <= 1'b0;
      cache_tag_reg   <= '0;
      cache_max_reg   <= '0;
      hit_reg         <= 1'b0;
    end else if (accept) begin
      hit_reg <= cache_hit && !sel_err;
      if (!sel_err && !cache_hit) begin
        cache_valid_reg <= 1'b1;
        cache_tag_reg   <= key_in;
        cache_max_reg   <= '0;
      end
    end else if (state_reg == EXPAND) begin
      cache_max_reg <= cnt_inc;
    end
  end
`else
  assign cache_hit  = 1'b0;
  assign finish_key = work_reg;
`endif

  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          if (sel_err || (round_sel == '0) || cache_hit) state_next = FINISH;
          else                                            state_next = EXPAND;
        end
      end
      EXPAND:  if (cnt_inc == target_reg) state_next = FINISH;
      FINISH:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg      <= '0;
      target_reg   <= '0;
      err_flag_reg <= 1'b0;
      work_reg     <= '0;
      busy         <= 1'b0;
      rk_valid     <= 1'b0;
      rk_idx       <= '0;
      rk_out       <= '0;
      done         <= 1'b0;
      err          <= 1'b0;
      key_out      <= '0;
    end else begin
      rk_valid <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      busy     <= (state_next != IDLE);
      case (state_reg)
        IDLE: begin
          if (start) begin
            work_reg     <= key_in;
            target_reg   <= round_sel;
            cnt_reg      <= '0;
            err_flag_reg <= sel_err;
          end
        end
        EXPAND: begin
          work_reg <= next_key;
          rk_valid <= 1'b1;
          rk_idx   <= cnt_inc;
          rk_out   <= next_key;
          cnt_reg  <= cnt_inc;
        end
        FINISH: begin
          done <= 1'b1;
          err  <= err_flag_reg;
          // An out-of-range request leaves the previous result in place.
          if (!err_flag_reg) key_out <= finish_key;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_round_key_engine.sv
// Scoreboard bench for aes_round_key_engine: FIPS-197 word-wise key expansion as reference model.
// Honours KEY_CACHE_EN when the design is built with it.
module tb_aes_round_key_engine;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [127:0] key_in = '0;
  logic [3:0]   round_sel = '0;
  logic         busy, rk_valid, done, err;
  logic [3:0]   rk_idx;
  logic [127:0] rk_out, key_out;

  aes_round_key_engine #(.KEY_W(128), .MAX_ROUND(10), .RC_W(4)) dut (
    .clk(clk), .rst(rst), .start(start), .key_in(key_in), .round_sel(round_sel),
    .busy(busy), .rk_valid(rk_valid), .rk_idx(rk_idx), .rk_out(rk_out),
    .done(done), .err(err), .key_out(key_out)
  );

  always #5 clk = ~clk;

  typedef struct { int idx; logic [127:0] key; } rk_t;
  typedef struct { logic err; logic [127:0] key; int lat; } done_t;

  rk_t   rk_q[$];
  done_t done_q[$];
  rk_t   mon_rk;
  done_t mon_done;

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  int cur_start = 0;
  int outstanding = 0;

  logic [7:0]   sbox_tab [0:255];
  logic [7:0]   rcon_tab [0:9];
  logic [127:0] cap_rk [0:15];
  logic [127:0] m_key_out = '0;
`ifdef KEY_CACHE_EN
  logic         m_valid = 1'b0;
  logic [127:0] m_tag = '0;
  int           m_max = 0;
`endif

  localparam logic [127:0] K = 128'h2b7e151628aed2a6abf7158809cf4f3c;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int k);
    return (x << k) | (x >> (8 - k));
  endfunction

  // S-box from the multiplicative walk over generator 3 and its inverse.
  task automatic build_sbox();
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ (p << 1) ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ (q << 1);
      q = q ^ (q << 2);
      q = q ^ (q << 4);
      if (q[7]) q = q ^ 8'h09;
      x = q ^ rotl8(q, 1) ^ rotl8(q, 2) ^ rotl8(q, 3) ^ rotl8(q, 4);
      sbox_tab[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sbox_tab[0] = 8'h63;
  endtask

  function automatic logic [127:0] ref_rk(input logic [127:0] key, input int r);
    logic [31:0] w [0:43];
    logic [31:0] t;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_tab[t[31:24]], sbox_tab[t[23:16]], sbox_tab[t[15:8]], sbox_tab[t[7:0]]}
            ^ {rcon_tab[i/4 - 1], 24'h000000};
      end
      w[i] = w[i-4] ^ t;
    end
    return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endfunction

  // Monitor: pops the scoreboard whenever the DUT presents a key or completion.
  always @(negedge clk) begin
    if (rk_valid === 1'b1) begin
      if (rk_q.size() == 0) begin
        chk("rk_unexpected", 128'(rk_valid), 128'(0));
      end else begin
        mon_rk = rk_q.pop_front();
        chk("rk_idx", 128'(rk_idx), 128'(mon_rk.idx));
        chk("rk_out", rk_out, mon_rk.key);
        chk("rk_cycle", 128'(cyc - cur_start), 128'(mon_rk.idx));
      end
      cap_rk[rk_idx] = rk_out;
    end
    if (done === 1'b1) begin
      if (done_q.size() == 0) begin
        chk("done_unexpected", 128'(done), 128'(0));
      end else begin
        mon_done = done_q.pop_front();
        chk("done_err", 128'(err), 128'(mon_done.err));
        chk("done_key_out", key_out, mon_done.key);
        chk("done_latency", 128'(cyc - cur_start + 1), 128'(mon_done.lat));
        chk("busy_at_done", 128'(busy), 128'(0));
        outstanding--;
      end
    end
  end

  task automatic issue(input logic [127:0] key, input logic [3:0] sel);
    logic  err_e, hit_e;
    done_t d;
    @(negedge clk);
    err_e = (sel > 4'd10);
    hit_e = 1'b0;
`ifdef KEY_CACHE_EN
    hit_e = !err_e && m_valid && (key == m_tag) && (int'(sel) <= m_max);
`endif
    if (!err_e && !hit_e)
      for (int i = 1; i <= int'(sel); i++) rk_q.push_back('{i, ref_rk(key, i)});
    if (!err_e) m_key_out = ref_rk(key, int'(sel));
    d.err = err_e;
    d.key = m_key_out;
    d.lat = (err_e || hit_e || sel == 4'd0) ? 2 : int'(sel) + 2;
    done_q.push_back(d);
    outstanding++;
`ifdef KEY_CACHE_EN
    if (!err_e && !hit_e) begin
      m_valid = 1'b1;
      m_tag   = key;
      m_max   = int'(sel);
    end
`endif
    start     = 1'b1;
    key_in    = key;
    round_sel = sel;
    @(posedge clk);
    #1;
    cur_start = cyc;
    start     = 1'b0;
    key_in    = {4{$urandom}};
    round_sel = 4'($urandom);
    chk("busy_after_start", 128'(busy), 128'(1));
  endtask

  task automatic wait_done();
    int k;
    k = 0;
    while (outstanding != 0 && k < 40) begin
      @(negedge clk);
      k++;
    end
    if (outstanding != 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL done_timeout: actual outstanding=%0d required=0", outstanding);
      rk_q.delete();
      done_q.delete();
      outstanding = 0;
    end
    chk("rk_all_seen", 128'(rk_q.size()), 128'(0));
  endtask

  task automatic run(input logic [127:0] key, input logic [3:0] sel);
    issue(key, sel);
    wait_done();
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_busy"}, 128'(busy), 128'(0));
    chk({tag, "_rk_valid"}, 128'(rk_valid), 128'(0));
    chk({tag, "_rk_idx"}, 128'(rk_idx), 128'(0));
    chk({tag, "_rk_out"}, rk_out, 128'(0));
    chk({tag, "_done"}, 128'(done), 128'(0));
    chk({tag, "_err"}, 128'(err), 128'(0));
    chk({tag, "_key_out"}, key_out, 128'(0));
  endtask

  initial begin
    logic [127:0] last_key, k2;
    logic [3:0]   sel;
    build_sbox();
    rcon_tab = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_outputs_zero("reset");
    rst = 1'b0;
    repeat (20) @(negedge clk);
    chk("idle_busy", 128'(busy), 128'(0));

    run(K, 4'd1);
    chk("vec_r1", cap_rk[1], 128'ha0fafe1788542cb123a339392a6c7605);
    run(K, 4'd10);
    chk("vec_r5", cap_rk[5], 128'hd4d1c6f87c839d87caf2b8bc11f915bc);
    chk("vec_r6", cap_rk[6], 128'h6d88a37a110b3efddbf98641ca0093fd);
    chk("vec_r10_key_out", key_out, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    run(K, 4'd6);
    chk("vec_r6_key_out", key_out, 128'h6d88a37a110b3efddbf98641ca0093fd);
    run(K, 4'd0);
    chk("r0_key_out", key_out, K);
    run(K, 4'd11);
    chk("err_key_out_kept", key_out, K);

    // Stray start with a different key while expanding must be ignored.
    k2 = {4{$urandom}};
    issue(k2, 4'd10);
    repeat (3) @(negedge clk);
    start     = 1'b1;
    key_in    = K;
    round_sel = 4'd2;
    @(negedge clk);
    start = 1'b0;
    wait_done();

    // Abort with reset once four rounds have been produced.
    k2 = {4{$urandom}};
    issue(k2, 4'd10);
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rk_q.delete();
    done_q.delete();
    outstanding = 0;
    m_key_out   = '0;
`ifdef KEY_CACHE_EN
    m_valid = 1'b0;
`endif
    @(negedge clk);
    chk_outputs_zero("abort");
    rst = 1'b0;
    repeat (5) @(negedge clk);
    run(K, 4'd6);
    chk("after_abort_key_out", key_out, 128'h6d88a37a110b3efddbf98641ca0093fd);

    last_key = K;
    for (int t = 0; t < 40; t++) begin
      if ($urandom_range(0, 2) != 0) last_key = {4{$urandom}};
      sel = 4'($urandom_range(0, 12));
      run(last_key, sel);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
